// File: rtl/mac_tx_sched.sv
// Time-aware transmit scheduler: prefetches TTE / best-effort frame pointers
// into one-entry heads and hands one descriptor at a time to the GMII MAC.
// TTE has strict priority; BE is held out of the TTE window and out of the
// tail of the period when its frame would not finish before the window opens.

// Per-class pointer prefetch head with length/guard evaluation.
module mac_tx_sched_pfq #(
    parameter int CYCLE_LEN = 100000,
    parameter int TTE_WIN   = 20000,
    parameter int BYTE_CYC  = 8,
    parameter int IFG_CYC   = 160,
    parameter int CW        = 20,
    parameter bit IS_TTE    = 1'b0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          run,
    input  logic [CW-1:0] cnt,
    input  logic [CW-1:0] cnt_eff,
    input  logic          empty,
    input  logic [15:0]   din,
    input  logic          clr,
    output logic          rd,
    output logic [15:0]   hd_ptr,
    output logic          elig_dec,
    output logic          blk
);
    typedef struct packed {
        logic        vld;
        logic [15:0] ptr;
    } head_t;

    localparam logic [CW:0] CL_W = (CW+1)'(CYCLE_LEN);

    head_t       hd;
    logic        rd_q;
    logic        eff_vld;
    logic [11:0] eff_len;

    // Wire time needed on the line for one frame, runts padded to 60 bytes.
    function automatic logic [CW-1:0] calc_need(input logic [11:0] len);
        logic [11:0] l;
        logic [47:0] p;
        l = (len < 12'd60) ? 12'd60 : len;
        p = 48'(l) * 48'(BYTE_CYC) + 48'(IFG_CYC);
        calc_need = (p > 48'({CW{1'b1}})) ? {CW{1'b1}} : p[CW-1:0];
    endfunction

    // Outside the TTE window and the frame finishes before the period wraps.
    function automatic logic fits(input logic [CW-1:0] c, input logic [CW-1:0] need);
        logic [CW:0] rem;
        rem  = CL_W - {1'b0, c};
        fits = (c >= CW'(TTE_WIN)) && (rem >= {1'b0, need});
    endfunction

    // One pop in flight at most: the pop issued last cycle blocks a new one.
    assign rd = run & ~hd.vld & ~empty & ~rd_q;

    // Head register: loads the popped word, cleared when the MAC takes it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q <= 1'b0;
            hd   <= '0;
        end else begin
            rd_q <= rd;
            if (clr) begin
                hd.vld <= 1'b0;
            end else if (rd_q) begin
                hd.vld <= 1'b1;
                hd.ptr <= din;
            end
        end
    end

    // The word arriving this cycle counts as the head for the grant decision.
    assign eff_vld  = hd.vld | rd_q;
    assign eff_len  = rd_q ? din[11:0] : hd.ptr[11:0];
    assign hd_ptr   = hd.ptr;
    assign elig_dec = IS_TTE ? eff_vld : (eff_vld & fits(cnt_eff, calc_need(eff_len)));
    assign blk      = IS_TTE ? 1'b0 : (hd.vld & ~fits(cnt, calc_need(hd.ptr[11:0])));
endmodule

// Scheduler top: schedule counter, two prefetch heads, grant FSM.
module mac_tx_sched #(
    parameter int CYCLE_LEN = 100000,
    parameter int TTE_WIN   = 20000,
    parameter int BYTE_CYC  = 8,
    parameter int IFG_CYC   = 160,
    parameter int CW        = 20
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cycle_start,
    input  logic        tte_ptr_empty,
    input  logic [15:0] tte_ptr_din,
    output logic        tte_ptr_rd,
    input  logic        be_ptr_empty,
    input  logic [15:0] be_ptr_din,
    output logic        be_ptr_rd,
    output logic        desc_valid,
    input  logic        desc_ready,
    output logic [15:0] desc_ptr,
    output logic        desc_tte,
    input  logic        tx_done,
    output logic        win_open,
    output logic        guard_block
);
    localparam int NCLS = 2;
    localparam int BE   = 0;
    localparam int TTE  = 1;

    typedef enum logic [1:0] {IDLE, GRANT, BUSY, IFG} state_t;

    state_t                   state, state_nxt;
    logic                     gnt_tte, gnt_nxt;
    logic [CW-1:0]            ifg_cnt, ifg_nxt;
    logic [CW-1:0]            cnt, cnt_eff;
    logic                     run_q;

    logic [NCLS-1:0]          cls_empty, cls_rd, cls_elig, cls_blk, cls_clr;
    logic [NCLS-1:0][15:0]    cls_din, cls_ptr;

    // Schedule counter; cycle_start resynchronises the period.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt   <= '0;
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (cycle_start)                    cnt <= '0;
            else if (cnt == CW'(CYCLE_LEN - 1)) cnt <= '0;
            else                                cnt <= cnt + 1'b1;
        end
    end

    // A sync pulse seen in IDLE is evaluated as if the period already restarted.
    assign cnt_eff = cycle_start ? '0 : cnt;

    assign cls_empty = {tte_ptr_empty, be_ptr_empty};
    assign cls_din   = {tte_ptr_din, be_ptr_din};

    for (genvar g = 0; g < NCLS; g++) begin : g_cls
        mac_tx_sched_pfq #(
            .CYCLE_LEN (CYCLE_LEN),
            .TTE_WIN   (TTE_WIN),
            .BYTE_CYC  (BYTE_CYC),
            .IFG_CYC   (IFG_CYC),
            .CW        (CW),
            .IS_TTE    (g == TTE)
        ) u_pfq (
            .clk      (clk),
            .rstn     (rstn),
            .run      (run_q),
            .cnt      (cnt),
            .cnt_eff  (cnt_eff),
            .empty    (cls_empty[g]),
            .din      (cls_din[g]),
            .clr      (cls_clr[g]),
            .rd       (cls_rd[g]),
            .hd_ptr   (cls_ptr[g]),
            .elig_dec (cls_elig[g]),
            .blk      (cls_blk[g])
        );
    end

    // FSM state, granted class and inter-frame gap counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            gnt_tte <= 1'b0;
            ifg_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gnt_tte <= gnt_nxt;
            ifg_cnt <= ifg_nxt;
        end
    end

    // Grant decision only in IDLE; an issued grant is never revoked.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_tte;
        ifg_nxt   = ifg_cnt;
        cls_clr   = '0;
        case (state)
            IDLE: begin
                ifg_nxt = '0;
                if (cls_elig[TTE]) begin
                    state_nxt = GRANT;
                    gnt_nxt   = 1'b1;
                end else if (cls_elig[BE]) begin
                    state_nxt = GRANT;
                    gnt_nxt   = 1'b0;
                end
            end
            GRANT: begin
                if (desc_ready) begin
                    cls_clr[gnt_tte ? TTE : BE] = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                ifg_nxt = '0;
                if (tx_done) state_nxt = IFG;
            end
            IFG: begin
                if (ifg_cnt == CW'(IFG_CYC - 1)) state_nxt = IDLE;
                else                             ifg_nxt   = ifg_cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign tte_ptr_rd  = cls_rd[TTE];
    assign be_ptr_rd   = cls_rd[BE];
    assign desc_valid  = (state == GRANT);
    assign desc_tte    = desc_valid & gnt_tte;
    assign desc_ptr    = desc_valid ? cls_ptr[gnt_tte ? TTE : BE] : 16'h0000;
    assign win_open    = run_q & (cnt < CW'(TTE_WIN));
    assign guard_block = |cls_blk;
endmodule

// File: tb/tb_mac_tx_sched.sv
// Bench for mac_tx_sched with a short schedule period: pointer FIFO model,
// schedule counter reference and a queue of expected grants.
module tb_mac_tx_sched;
    localparam int CL = 1000;
    localparam int TW = 200;
    localparam int BC = 1;
    localparam int IG = 20;
    localparam int CW = 20;

    typedef struct {
        logic        tte;
        logic [15:0] ptr;
    } exp_t;

    logic        clk = 1'b0, rstn = 1'b0, cycle_start = 1'b0;
    logic        tte_ptr_empty, be_ptr_empty, tte_ptr_rd, be_ptr_rd;
    logic [15:0] tte_ptr_din = '0, be_ptr_din = '0, desc_ptr;
    logic        desc_valid, desc_ready = 1'b1, desc_tte, tx_done = 1'b0;
    logic        win_open, guard_block;

    logic [15:0] tmem [64];
    logic [15:0] bmem [64];
    int          t_push = 0, b_push = 0, t_pop = 0, b_pop = 0;
    int          tb_cnt = 0;
    int          n_chk = 0, n_pass = 0;
    exp_t        sb [$];

    mac_tx_sched #(.CYCLE_LEN(CL), .TTE_WIN(TW), .BYTE_CYC(BC), .IFG_CYC(IG), .CW(CW)) dut (
        .clk(clk), .rstn(rstn), .cycle_start(cycle_start),
        .tte_ptr_empty(tte_ptr_empty), .tte_ptr_din(tte_ptr_din), .tte_ptr_rd(tte_ptr_rd),
        .be_ptr_empty(be_ptr_empty), .be_ptr_din(be_ptr_din), .be_ptr_rd(be_ptr_rd),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_ptr(desc_ptr),
        .desc_tte(desc_tte), .tx_done(tx_done), .win_open(win_open), .guard_block(guard_block)
    );

    always #5 clk = ~clk;

    assign tte_ptr_empty = (t_push == t_pop);
    assign be_ptr_empty  = (b_push == b_pop);

    // Pointer FIFOs: data appears the cycle after a pop.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            t_pop <= 0;
            b_pop <= 0;
        end else begin
            if (tte_ptr_rd) begin tte_ptr_din <= tmem[t_pop[5:0]]; t_pop <= t_pop + 1; end
            if (be_ptr_rd)  begin be_ptr_din  <= bmem[b_pop[5:0]]; b_pop <= b_pop + 1; end
        end
    end

    // Reference schedule counter.
    always @(posedge clk or negedge rstn) begin
        if (!rstn)              tb_cnt <= 0;
        else if (cycle_start)   tb_cnt <= 0;
        else if (tb_cnt == CL-1) tb_cnt <= 0;
        else                    tb_cnt <= tb_cnt + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_tte(input logic [15:0] p, input bit exp);
        tmem[t_push[5:0]] = p;
        t_push++;
        if (exp) sb.push_back('{1'b1, p});
    endtask

    task automatic push_be(input logic [15:0] p, input bit exp);
        bmem[b_push[5:0]] = p;
        b_push++;
        if (exp) sb.push_back('{1'b0, p});
    endtask

    task automatic sb_pop(output exp_t e);
        e.tte = 1'bx;
        e.ptr = 16'hxxxx;
        if (sb.size() > 0) e = sb.pop_front();
    endtask

    task automatic wait_cnt(input int c);
        for (int i = 0; i < 2*CL + 10; i++) begin
            if (tb_cnt == c) break;
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int max, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < max; i++) begin
            if (desc_valid === 1'b1) begin ok = 1'b1; n = i; break; end
            @(negedge clk);
        end
    endtask

    task automatic tx_pulse();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        bit ok; int n;
        repeat (2) tick();
        n_chk++;
        if ({desc_valid, tte_ptr_rd, be_ptr_rd, guard_block, win_open, desc_tte, desc_ptr} !== '0)
            $display("FAIL reset_outs: got v=%b trd=%b brd=%b gb=%b wo=%b tte=%b ptr=%h, want all 0",
                     desc_valid, tte_ptr_rd, be_ptr_rd, guard_block, win_open, desc_tte, desc_ptr);
        else n_pass++;
        rstn = 1'b1;
        repeat (2) tick();
        n_chk++;
        if (win_open !== 1'b1) $display("FAIL reset_win_open: got %b want 1", win_open);
        else n_pass++;
        desc_ready = 1'b0;
        push_tte(16'h0040, 1'b0);
        push_be(16'h0100, 1'b0);
        wait_valid(10, ok, n);
        n_chk++;
        if (!ok) $display("FAIL t1_grant: desc_valid not raised within 10 cycles");
        else n_pass++;
        repeat (2) tick();
        rstn = 1'b0;
        #1;
        n_chk++;
        if ({desc_valid, tte_ptr_rd, be_ptr_rd, guard_block, win_open} !== 5'b0)
            $display("FAIL t1_async: got v=%b trd=%b brd=%b gb=%b wo=%b want 0",
                     desc_valid, tte_ptr_rd, be_ptr_rd, guard_block, win_open);
        else n_pass++;
        t_push = 0;
        b_push = 0;
        sb.delete();
        desc_ready = 1'b1;
        repeat (2) tick();
        rstn = 1'b1;
        repeat (5) tick();
        n_chk++;
        if ({desc_valid, guard_block} !== 2'b00)
            $display("FAIL t1_discard: got v=%b gb=%b want 0 0 (heads discarded)", desc_valid, guard_block);
        else n_pass++;
    endtask

    task automatic test_priority();
        bit ok; int n; exp_t e;
        wait_cnt(50);
        push_tte(16'h1064, 1'b1);
        push_be(16'h5064, 1'b1);
        wait_valid(10, ok, n);
        n_chk++;
        if (tb_cnt != 52) $display("FAIL t2_latency: first grant at cnt %0d want 52", tb_cnt);
        else n_pass++;
        sb_pop(e);
        n_chk++;
        if ({desc_tte, desc_ptr} !== {e.tte, e.ptr})
            $display("FAIL t2_first: got tte=%b ptr=%h want tte=%b ptr=%h", desc_tte, desc_ptr, e.tte, e.ptr);
        else n_pass++;
        tick();
        n_chk++;
        if ({desc_valid, guard_block} !== 2'b01)
            $display("FAIL t2_guard: got v=%b gb=%b want 0 1", desc_valid, guard_block);
        else n_pass++;
        repeat (3) tick();
        tx_pulse();
        wait_valid(300, ok, n);
        n_chk++;
        if (!ok || tb_cnt < TW || tb_cnt > TW+1)
            $display("FAIL t2_be_time: ok=%b grant at cnt %0d want %0d..%0d", ok, tb_cnt, TW, TW+1);
        else n_pass++;
        sb_pop(e);
        n_chk++;
        if ({desc_tte, desc_ptr} !== {e.tte, e.ptr})
            $display("FAIL t2_second: got tte=%b ptr=%h want tte=%b ptr=%h", desc_tte, desc_ptr, e.tte, e.ptr);
        else n_pass++;
        tick();
        tx_pulse();
        repeat (IG+3) tick();
    endtask

    task automatic test_window();
        bit ok; int n; exp_t e;
        wait_cnt(100);
        push_be(16'hA064, 1'b1);
        repeat (4) tick();
        n_chk++;
        if ({guard_block, desc_valid, win_open} !== 3'b101)
            $display("FAIL t3_guard: got gb=%b v=%b wo=%b want 1 0 1", guard_block, desc_valid, win_open);
        else n_pass++;
        wait_valid(200, ok, n);
        n_chk++;
        if (!ok || tb_cnt < TW || tb_cnt > TW+1)
            $display("FAIL t3_rise: ok=%b desc_valid rose at cnt %0d want %0d..%0d", ok, tb_cnt, TW, TW+1);
        else n_pass++;
        sb_pop(e);
        n_chk++;
        if ({desc_tte, desc_ptr} !== {e.tte, e.ptr})
            $display("FAIL t3_ptr: got tte=%b ptr=%h want tte=%b ptr=%h", desc_tte, desc_ptr, e.tte, e.ptr);
        else n_pass++;
        tick();
        tx_pulse();
        repeat (IG+3) tick();
    endtask

    task automatic test_guard_len();
        bit ok; int n; exp_t e; bit seen_v; bit gb_all;
        wait_cnt(600);
        push_be(16'h312C, 1'b1);
        wait_valid(5, ok, n);
        sb_pop(e);
        n_chk++;
        if (!ok || tb_cnt != 602 || {desc_tte, desc_ptr} !== {e.tte, e.ptr})
            $display("FAIL t4_fit: ok=%b cnt=%0d ptr=%h want cnt 602 ptr=%h", ok, tb_cnt, desc_ptr, e.ptr);
        else n_pass++;
        tick();
        tx_pulse();
        repeat (IG+3) tick();
        wait_cnt(679);
        push_be(16'h412C, 1'b1);
        wait_valid(5, ok, n);
        sb_pop(e);
        n_chk++;
        if (!ok || {desc_tte, desc_ptr} !== {e.tte, e.ptr})
            $display("FAIL t4_exact: ok=%b ptr=%h want grant with rem==need ptr=%h", ok, desc_ptr, e.ptr);
        else n_pass++;
        tick();
        tx_pulse();
        repeat (IG+3) tick();
        wait_cnt(500);
        push_be(16'h55DC, 1'b0);
        repeat (3) tick();
        seen_v = 1'b0;
        gb_all = 1'b1;
        for (int i = 0; i < CL; i++) begin
            if (desc_valid !== 1'b0) seen_v = 1'b1;
            if (guard_block !== 1'b1) gb_all = 1'b0;
            tick();
        end
        n_chk++;
        if (seen_v !== 1'b0) $display("FAIL t4_blocked: got grant for oversize BE, want none");
        else n_pass++;
        n_chk++;
        if (gb_all !== 1'b1) $display("FAIL t4_guard_all: got guard_block drop, want 1 for whole period");
        else n_pass++;
        rstn = 1'b0;
        t_push = 0;
        b_push = 0;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        n_chk++;
        if (guard_block !== 1'b0) $display("FAIL t4_reset_discard: got gb=%b want 0", guard_block);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        bit ok; int n; exp_t e; bit stable; bit seen_v;
        desc_ready = 1'b0;
        push_tte(16'h7040, 1'b1);
        wait_valid(5, ok, n);
        stable = ok;
        for (int i = 0; i < 10; i++) begin
            if (desc_valid !== 1'b1 || desc_ptr !== 16'h7040 || desc_tte !== 1'b1) stable = 1'b0;
            tx_done = (i == 4);
            tick();
        end
        tx_done = 1'b0;
        n_chk++;
        if (stable !== 1'b1 || desc_valid !== 1'b1)
            $display("FAIL t5_stable: got v=%b ptr=%h stable=%b want held 10 cycles", desc_valid, desc_ptr, stable);
        else n_pass++;
        desc_ready = 1'b1;
        sb_pop(e);
        n_chk++;
        if ({desc_tte, desc_ptr} !== {e.tte, e.ptr})
            $display("FAIL t5_ptr: got tte=%b ptr=%h want tte=%b ptr=%h", desc_tte, desc_ptr, e.tte, e.ptr);
        else n_pass++;
        tick();
        push_tte(16'h8040, 1'b1);
        seen_v = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (desc_valid !== 1'b0) seen_v = 1'b1;
            tick();
        end
        n_chk++;
        if (seen_v !== 1'b0) $display("FAIL t5_busy_hold: got grant before tx_done, want none");
        else n_pass++;
        tx_pulse();
        wait_valid(40, ok, n);
        n_chk++;
        if (!ok || n != IG+1) $display("FAIL t5_ifg_gap: ok=%b gap=%0d want %0d", ok, n+1, IG+2);
        else n_pass++;
        sb_pop(e);
        n_chk++;
        if ({desc_tte, desc_ptr} !== {e.tte, e.ptr})
            $display("FAIL t5_second: got tte=%b ptr=%h want tte=%b ptr=%h", desc_tte, desc_ptr, e.tte, e.ptr);
        else n_pass++;
        tick();
        tx_pulse();
        repeat (IG+3) tick();
    endtask

    task automatic test_cycle_start();
        bit ok; int n; exp_t e; bit seen_v; bit gb_all;
        wait_cnt(650);
        push_tte(16'h9040, 1'b1);
        push_be(16'hB00A, 1'b1);
        wait_valid(5, ok, n);
        sb_pop(e);
        n_chk++;
        if (!ok || {desc_tte, desc_ptr} !== {e.tte, e.ptr})
            $display("FAIL t6_tte: ok=%b tte=%b ptr=%h want tte=%b ptr=%h", ok, desc_tte, desc_ptr, e.tte, e.ptr);
        else n_pass++;
        tick();
        wait_cnt(700);
        n_chk++;
        if (guard_block !== 1'b0) $display("FAIL t6_pre: got gb=%b want 0 at cnt 700", guard_block);
        else n_pass++;
        cycle_start = 1'b1;
        tick();
        cycle_start = 1'b0;
        n_chk++;
        if ({win_open, guard_block, desc_valid} !== 3'b110)
            $display("FAIL t6_after: got wo=%b gb=%b v=%b want 1 1 0", win_open, guard_block, desc_valid);
        else n_pass++;
        tx_pulse();
        seen_v = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (desc_valid !== 1'b0) seen_v = 1'b1;
            tick();
        end
        n_chk++;
        if (seen_v !== 1'b0) $display("FAIL t6_blocked: got BE grant inside window, want none");
        else n_pass++;
        wait_valid(200, ok, n);
        sb_pop(e);
        n_chk++;
        if (!ok || tb_cnt < TW || tb_cnt > TW+1 || {desc_tte, desc_ptr} !== {e.tte, e.ptr})
            $display("FAIL t6_be: ok=%b cnt=%0d ptr=%h want cnt %0d..%0d ptr=%h", ok, tb_cnt, desc_ptr, TW, TW+1, e.ptr);
        else n_pass++;
        tick();
        tx_pulse();
        repeat (IG+3) tick();
        wait_cnt(920);
        push_be(16'hC00A, 1'b1);
        seen_v = 1'b0;
        gb_all = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            if (desc_valid !== 1'b0) seen_v = 1'b1;
            if (guard_block !== 1'b1) gb_all = 1'b0;
            tick();
        end
        n_chk++;
        if (seen_v !== 1'b0 || gb_all !== 1'b1)
            $display("FAIL t6_minlen: got grant=%b guard_all=%b want 0 1 (runt counts as 60 bytes)", seen_v, gb_all);
        else n_pass++;
        wait_valid(400, ok, n);
        sb_pop(e);
        n_chk++;
        if (!ok || {desc_tte, desc_ptr} !== {e.tte, e.ptr})
            $display("FAIL t6_minlen_grant: ok=%b ptr=%h want ptr=%h", ok, desc_ptr, e.ptr);
        else n_pass++;
        tick();
        tx_pulse();
        repeat (IG+3) tick();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_window();
        test_guard_len();
        test_back_pressure();
        test_cycle_start();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end
endmodule
